// File: rtl/pixel_scan_mux.sv
// ---------------------------------------------------------------------------
// pixel_scan_mux
//
// Double-buffered row serializer for the matrix column driver. Row words of
// WIDTH pixels arrive over a valid/ready handshake. They are parked in a
// shadow buffer and then moved into an active register. The active word is
// emitted one pixel at a time, and each pixel is held for DIV clock cycles.
// The scan direction is chosen per word, and a change takes effect at word
// boundaries only.
//
// Ports
//   clk          in  1      rising-edge clock
//   rst          in  1      asynchronous active-high reset
//   dout         in  WIDTH  row word to display
//   din_valid    in  1      dout / msb_first valid
//   din_ready    out 1      shadow buffer empty
//   msb_first    in  1      scan direction of the offered word
//   pixel        out 1      current pixel (0 when not scanning)
//   pixel_valid  out 1      a word is being scanned
//   sel          out SEL_W  current column index
//   row_done     out 1      pulse: last pixel of a word completed
//   underrun     out 1      pulse: word completed with the shadow empty
// ---------------------------------------------------------------------------
module pixel_scan_mux #(
   parameter int WIDTH = 8,
   parameter int SEL_W = 3,
   parameter int DIV   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] dout,
   input  logic             din_valid,
   output logic             din_ready,
   input  logic             msb_first,
   output logic             pixel,
   output logic             pixel_valid,
   output logic [SEL_W-1:0] sel,
   output logic             row_done,
   output logic             underrun
);

   // When DIV is 1, the counter has one bit and it stays at 0.
   localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV - 1);
   localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(WIDTH - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t             state_q, state_d;

   // Shadow buffer, written by the input handshake.
   logic [WIDTH-1:0]   shadow_data_q, shadow_data_d;
   logic               shadow_dir_q, shadow_dir_d;
   logic               shadow_full_q, shadow_full_d;

   // The word being scanned.
   logic [WIDTH-1:0]   active_q, active_d;
   logic               dir_q, dir_d;
   logic [SEL_W-1:0]   sel_q, sel_d;
   logic [CNT_W-1:0]   div_cnt_q, div_cnt_d;

   // Registered outputs.
   logic               pixel_q, pixel_d;
   logic               pixel_valid_q, pixel_valid_d;
   logic               row_done_q, row_done_d;
   logic               underrun_q, underrun_d;

   logic               accept;
   logic               take_shadow;
   logic               div_last;
   logic               col_last;

   // ------------------------------------------------------------------
   // Input side: a word is taken only when the shadow is empty. The shadow
   // can be drained only while it is full, so an accept and a drain never
   // happen on the same edge.
   // ------------------------------------------------------------------
   assign accept = din_valid & ~shadow_full_q;

   always_comb begin
      shadow_data_d = shadow_data_q;
      shadow_dir_d  = shadow_dir_q;
      shadow_full_d = shadow_full_q;
      if (accept) begin
         shadow_data_d = dout;
         shadow_dir_d  = msb_first;
         shadow_full_d = 1'b1;
      end else if (take_shadow) begin
         shadow_full_d = 1'b0;
      end
   end

   // ------------------------------------------------------------------
   // Scan sequencer
   // ------------------------------------------------------------------
   assign div_last = (div_cnt_q == DIV_LAST);
   // The last column depends on the direction of the word now being scanned.
   assign col_last = dir_q ? (sel_q == '0) : (sel_q == SEL_LAST);

   always_comb begin
      state_d       = state_q;
      active_d      = active_q;
      dir_d         = dir_q;
      sel_d         = sel_q;
      div_cnt_d     = div_cnt_q;
      pixel_valid_d = pixel_valid_q;
      row_done_d    = 1'b0;
      underrun_d    = 1'b0;
      take_shadow   = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (shadow_full_q) begin
               take_shadow   = 1'b1;
               state_d       = SHIFT;
               pixel_valid_d = 1'b1;
            end
         end

         SHIFT: begin
            if (div_last) begin
               if (col_last) begin
                  row_done_d = 1'b1;
                  if (shadow_full_q) begin
                     // Chain straight into the next word with no gap cycle.
                     take_shadow = 1'b1;
                  end else begin
                     state_d       = IDLE;
                     pixel_valid_d = 1'b0;
                     sel_d         = '0;
                     div_cnt_d     = '0;
                     underrun_d    = 1'b1;
                  end
               end else begin
                  sel_d     = dir_q ? (sel_q - SEL_W'(1)) : (sel_q + SEL_W'(1));
                  div_cnt_d = '0;
               end
            end else begin
               div_cnt_d = div_cnt_q + CNT_W'(1);
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      // Load the shadow word. The first column depends on the new word's
      // direction, not on the direction of the word that just finished.
      if (take_shadow) begin
         active_d  = shadow_data_q;
         dir_d     = shadow_dir_q;
         sel_d     = shadow_dir_q ? SEL_LAST : '0;
         div_cnt_d = '0;
      end
   end

   // The pixel is looked up from next-state values so that it stays in the
   // same cycle as sel and is still driven by a register.
   always_comb begin
      pixel_d = pixel_valid_d & active_d[sel_d];
   end

   // ------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         shadow_data_q <= '0;
         shadow_dir_q  <= 1'b0;
         shadow_full_q <= 1'b0;
         active_q      <= '0;
         dir_q         <= 1'b0;
         sel_q         <= '0;
         div_cnt_q     <= '0;
         pixel_q       <= 1'b0;
         pixel_valid_q <= 1'b0;
         row_done_q    <= 1'b0;
         underrun_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         shadow_data_q <= shadow_data_d;
         shadow_dir_q  <= shadow_dir_d;
         shadow_full_q <= shadow_full_d;
         active_q      <= active_d;
         dir_q         <= dir_d;
         sel_q         <= sel_d;
         div_cnt_q     <= div_cnt_d;
         pixel_q       <= pixel_d;
         pixel_valid_q <= pixel_valid_d;
         row_done_q    <= row_done_d;
         underrun_q    <= underrun_d;
      end
   end

   assign din_ready   = ~shadow_full_q;
   assign pixel       = pixel_q;
   assign pixel_valid = pixel_valid_q;
   assign sel         = sel_q;
   assign row_done    = row_done_q;
   assign underrun    = underrun_q;

endmodule

// File: tb/tb_pixel_scan_mux.sv
// ---------------------------------------------------------------------------
// tb_pixel_scan_mux
//
// Directed testbench for pixel_scan_mux. Instance A uses DIV=1 and instance B
// uses DIV=4. Both share clk, rst, dout and msb_first, and each has its own
// din_valid. Inputs change 1 ns after the rising edge, and outputs are
// sampled at that same point.
// ---------------------------------------------------------------------------
module tb_pixel_scan_mux;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] dout = 8'h00;
   logic       msb_first = 1'b0;

   logic       din_valid_a = 1'b0;
   logic       din_ready_a;
   logic       pixel_a, pixel_valid_a, row_done_a, underrun_a;
   logic [2:0] sel_a;

   logic       din_valid_b = 1'b0;
   logic       din_ready_b;
   logic       pixel_b, pixel_valid_b, row_done_b, underrun_b;
   logic [2:0] sel_b;

   int pass_cnt  = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   pixel_scan_mux #(.WIDTH(8), .SEL_W(3), .DIV(1)) dut_a (
      .clk(clk), .rst(rst), .dout(dout), .din_valid(din_valid_a),
      .din_ready(din_ready_a), .msb_first(msb_first), .pixel(pixel_a),
      .pixel_valid(pixel_valid_a), .sel(sel_a), .row_done(row_done_a),
      .underrun(underrun_a)
   );

   pixel_scan_mux #(.WIDTH(8), .SEL_W(3), .DIV(4)) dut_b (
      .clk(clk), .rst(rst), .dout(dout), .din_valid(din_valid_b),
      .din_ready(din_ready_b), .msb_first(msb_first), .pixel(pixel_b),
      .pixel_valid(pixel_valid_b), .sel(sel_b), .row_done(row_done_b),
      .underrun(underrun_b)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // -----------------------------------------------------------------
   task automatic test_reset();
      rst = 1'b1;
      din_valid_a = 1'b1;
      dout = 8'hA5;
      step(); step(); step();
      total_cnt++; if ({pixel_a, pixel_valid_a, sel_a, row_done_a, underrun_a} !== 7'b0)
         $display("FAIL reset_outs_a: got %b want 0", {pixel_a, pixel_valid_a, sel_a, row_done_a, underrun_a});
      else pass_cnt++;
      total_cnt++; if (din_ready_a !== 1'b1)
         $display("FAIL reset_ready_a: got %b want 1", din_ready_a);
      else pass_cnt++;
      total_cnt++; if ({pixel_b, pixel_valid_b, sel_b, row_done_b, underrun_b, din_ready_b} !== 8'b1)
         $display("FAIL reset_outs_b: got %b want 00000001", {pixel_b, pixel_valid_b, sel_b, row_done_b, underrun_b, din_ready_b});
      else pass_cnt++;
      rst = 1'b0;
      din_valid_a = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         total_cnt++; if (pixel_valid_a !== 1'b0 || din_ready_a !== 1'b1)
            $display("FAIL reset_idle: cyc %0d valid=%b ready=%b want 0/1", i, pixel_valid_a, din_ready_a);
         else pass_cnt++;
      end
      $display("reset done");
   endtask

   // -----------------------------------------------------------------
   task automatic test_lsb_div1();
      logic [7:0] w;
      w = 8'hA5;
      dout = w; msb_first = 1'b0; din_valid_a = 1'b1;
      step();                       // accept
      din_valid_a = 1'b0;
      total_cnt++; if (din_ready_a !== 1'b0)
         $display("FAIL lsb_ready_after_accept: got %b want 0", din_ready_a);
      else pass_cnt++;
      total_cnt++; if (pixel_valid_a !== 1'b0)
         $display("FAIL lsb_latency: valid=%b want 0 one edge after accept", pixel_valid_a);
      else pass_cnt++;
      step();                       // load
      for (int i = 0; i < 8; i++) begin
         total_cnt++; if (pixel_valid_a !== 1'b1 || sel_a !== 3'(i) || pixel_a !== w[i] || row_done_a !== 1'b0)
            $display("FAIL lsb_scan: cyc %0d got v=%b sel=%0d px=%b rd=%b want 1/%0d/%b/0",
                     i, pixel_valid_a, sel_a, pixel_a, row_done_a, i, w[i]);
         else pass_cnt++;
         step();
      end
      total_cnt++; if (row_done_a !== 1'b1 || underrun_a !== 1'b1 || pixel_valid_a !== 1'b0 || sel_a !== 3'd0 || pixel_a !== 1'b0)
         $display("FAIL lsb_end: rd=%b ur=%b v=%b sel=%0d px=%b want 1/1/0/0/0",
                  row_done_a, underrun_a, pixel_valid_a, sel_a, pixel_a);
      else pass_cnt++;
      step();
      total_cnt++; if (row_done_a !== 1'b0 || underrun_a !== 1'b0)
         $display("FAIL lsb_pulse_len: rd=%b ur=%b want 0/0", row_done_a, underrun_a);
      else pass_cnt++;
      $display("word A5 lsb-first DIV=1 scanned");
   endtask

   // -----------------------------------------------------------------
   task automatic test_msb_div4();
      logic [7:0] w;
      int         es;
      w = 8'h81;
      dout = w; msb_first = 1'b1; din_valid_b = 1'b1;
      step();
      din_valid_b = 1'b0;
      step();
      for (int c = 0; c < 32; c++) begin
         es = 7 - c / 4;
         total_cnt++; if (pixel_valid_b !== 1'b1 || sel_b !== 3'(es) || pixel_b !== ((c < 4 || c >= 28) ? 1'b1 : 1'b0) || row_done_b !== 1'b0)
            $display("FAIL msb_scan: cyc %0d got v=%b sel=%0d px=%b rd=%b want 1/%0d/%b/0",
                     c, pixel_valid_b, sel_b, pixel_b, row_done_b, es, (c < 4 || c >= 28));
         else pass_cnt++;
         step();
      end
      total_cnt++; if (row_done_b !== 1'b1 || underrun_b !== 1'b1 || pixel_valid_b !== 1'b0)
         $display("FAIL msb_end: rd=%b ur=%b v=%b want 1/1/0", row_done_b, underrun_b, pixel_valid_b);
      else pass_cnt++;
      step();
      $display("word 81 msb-first DIV=4 scanned");
   endtask

   // -----------------------------------------------------------------
   task automatic test_back_to_back();
      logic erd;
      dout = 8'hFF; msb_first = 1'b0; din_valid_a = 1'b1;
      step();                       // accept FF
      dout = 8'h00;
      step();                       // load FF, shadow free
      for (int c = 0; c < 16; c++) begin
         if (c == 1) din_valid_a = 1'b0;   // 00 was taken at the previous edge
         erd = (c == 8);
         total_cnt++; if (pixel_valid_a !== 1'b1 || sel_a !== 3'(c % 8) || pixel_a !== ((c < 8) ? 1'b1 : 1'b0)
                          || row_done_a !== erd || underrun_a !== 1'b0)
            $display("FAIL b2b_scan: cyc %0d got v=%b sel=%0d px=%b rd=%b ur=%b want 1/%0d/%b/%b/0",
                     c, pixel_valid_a, sel_a, pixel_a, row_done_a, underrun_a, c % 8, (c < 8), erd);
         else pass_cnt++;
         step();
      end
      total_cnt++; if (row_done_a !== 1'b1 || underrun_a !== 1'b1 || pixel_valid_a !== 1'b0)
         $display("FAIL b2b_end: rd=%b ur=%b v=%b want 1/1/0", row_done_a, underrun_a, pixel_valid_a);
      else pass_cnt++;
      step();
      $display("words FF,00 back-to-back scanned");
   endtask

   // -----------------------------------------------------------------
   task automatic test_shadow_full();
      logic [7:0] words [3];
      logic       dirs  [3];
      logic [7:0] w;
      int         es;
      logic       erdy, erd;
      words[0] = 8'h3C; dirs[0] = 1'b0;
      words[1] = 8'hC3; dirs[1] = 1'b1;
      words[2] = 8'h5A; dirs[2] = 1'b0;
      dout = words[0]; msb_first = dirs[0]; din_valid_a = 1'b1;
      step();                       // accept W1
      dout = words[1]; msb_first = dirs[1];
      step();                       // load W1
      for (int c = 0; c < 24; c++) begin
         if (c == 1) begin dout = words[2]; msb_first = dirs[2]; end
         if (c == 9) din_valid_a = 1'b0;   // W3 was taken at the previous edge
         w    = words[c / 8];
         es   = dirs[c / 8] ? 7 - (c % 8) : (c % 8);
         erdy = (c == 0 || c == 8 || c >= 16);
         erd  = (c == 8 || c == 16);
         total_cnt++; if (pixel_valid_a !== 1'b1 || sel_a !== 3'(es) || pixel_a !== w[es]
                          || din_ready_a !== erdy || row_done_a !== erd || underrun_a !== 1'b0)
            $display("FAIL full_scan: cyc %0d got v=%b sel=%0d px=%b rdy=%b rd=%b ur=%b want 1/%0d/%b/%b/%b/0",
                     c, pixel_valid_a, sel_a, pixel_a, din_ready_a, row_done_a, underrun_a, es, w[es], erdy, erd);
         else pass_cnt++;
         step();
      end
      total_cnt++; if (row_done_a !== 1'b1 || underrun_a !== 1'b1 || pixel_valid_a !== 1'b0)
         $display("FAIL full_end: rd=%b ur=%b v=%b want 1/1/0", row_done_a, underrun_a, pixel_valid_a);
      else pass_cnt++;
      step();
      $display("words 3C,C3,5A with stalled third word scanned");
   endtask

   // -----------------------------------------------------------------
   task automatic test_reset_mid_word();
      dout = 8'hFF; msb_first = 1'b0; din_valid_a = 1'b1;
      step();                       // accept FF
      step();                       // load FF, c0; shadow gets FF next edge
      step();                       // c1
      din_valid_a = 1'b0;
      step(); step();               // c3
      total_cnt++; if (sel_a !== 3'd3 || pixel_valid_a !== 1'b1 || din_ready_a !== 1'b0)
         $display("FAIL rstmid_pre: sel=%0d v=%b rdy=%b want 3/1/0", sel_a, pixel_valid_a, din_ready_a);
      else pass_cnt++;
      #3 rst = 1'b1;
      #1;
      total_cnt++; if (pixel_valid_a !== 1'b0 || pixel_a !== 1'b0 || sel_a !== 3'd0 || din_ready_a !== 1'b1)
         $display("FAIL rstmid_async: v=%b px=%b sel=%0d rdy=%b want 0/0/0/1", pixel_valid_a, pixel_a, sel_a, din_ready_a);
      else pass_cnt++;
      step();
      rst = 1'b0;
      for (int i = 0; i < 12; i++) begin
         step();
         total_cnt++; if (pixel_valid_a !== 1'b0 || pixel_a !== 1'b0 || row_done_a !== 1'b0)
            $display("FAIL rstmid_idle: cyc %0d v=%b px=%b rd=%b want 0/0/0", i, pixel_valid_a, pixel_a, row_done_a);
         else pass_cnt++;
      end
      dout = 8'h01; msb_first = 1'b0; din_valid_a = 1'b1;
      step();
      din_valid_a = 1'b0;
      step();
      total_cnt++; if (pixel_valid_a !== 1'b1 || sel_a !== 3'd0 || pixel_a !== 1'b1)
         $display("FAIL rstmid_recover: v=%b sel=%0d px=%b want 1/0/1", pixel_valid_a, sel_a, pixel_a);
      else pass_cnt++;
      for (int i = 0; i < 9; i++) step();
      $display("reset mid-word handled");
   endtask

   initial begin
      test_reset();
      test_lsb_div1();
      test_msb_div4();
      test_back_to_back();
      test_shadow_full();
      test_reset_mid_word();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
